// File: rtl/softex_slot_regfile.sv
`default_nettype none
// ============================================================================
// Module      : softex_slot_regfile
// Description : Responder side of the softex slot protocol. Holds N_SLOTS
//               softmax state slots (running maximum + denominator per lane)
//               so partial row reductions can be parked and resumed.
//               Request channel : ALLOC / LOAD, answered through a single
//                                 output register (rsp_*).
//               Update channel  : UPDATE / FREE, single-cycle, always-ready
//                                 while idle.
//               flush_i walks every slot and invalidates it, one per cycle.
// Ports       : clk_i, rst_i (sync, active high), flush_i
//               req_valid_i/req_ready_o/req_op_i/req_addr_i
//               rsp_valid_o/rsp_ready_i/rsp_addr_o/rsp_hit_o/
//               rsp_maximum_o/rsp_denominator_o
//               upd_valid_i/upd_ready_o/upd_op_i/upd_addr_i/
//               upd_maximum_i/upd_denominator_i
//               occupancy_o (valid slot count), busy_o (flush in progress)
// Options     : SOFTEX_SLOT_STATS_EN adds stat_hits_o / stat_misses_o.
// Revision    : 1.0 - initial release
// ============================================================================
module softex_slot_regfile #(
  parameter int unsigned          N_SLOTS        = 4,
  parameter int unsigned          SLOT_ADDR_BITS = 8,
  parameter int unsigned          WIDTH_IN       = 16,
  parameter int unsigned          WIDTH_ACC      = 32,
  parameter int unsigned          NUM_LANES      = 1,
  parameter logic [WIDTH_IN-1:0]  MAX_RESET      = 16'hFF80
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              flush_i,
  input  logic                              req_valid_i,
  output logic                              req_ready_o,
  input  logic                              req_op_i,
  input  logic [SLOT_ADDR_BITS-1:0]         req_addr_i,
  output logic                              rsp_valid_o,
  input  logic                              rsp_ready_i,
  output logic [SLOT_ADDR_BITS-1:0]         rsp_addr_o,
  output logic                              rsp_hit_o,
  output logic [NUM_LANES*WIDTH_IN-1:0]     rsp_maximum_o,
  output logic [NUM_LANES*WIDTH_ACC-1:0]    rsp_denominator_o,
  input  logic                              upd_valid_i,
  output logic                              upd_ready_o,
  input  logic                              upd_op_i,
  input  logic [SLOT_ADDR_BITS-1:0]         upd_addr_i,
  input  logic [NUM_LANES*WIDTH_IN-1:0]     upd_maximum_i,
  input  logic [NUM_LANES*WIDTH_ACC-1:0]    upd_denominator_i,
  output logic [$clog2(N_SLOTS):0]          occupancy_o,
`ifdef SOFTEX_SLOT_STATS_EN
  output logic [31:0]                       stat_hits_o,
  output logic [31:0]                       stat_misses_o,
`endif
  output logic                              busy_o
);

  localparam int unsigned c_idx_w = $clog2(N_SLOTS);
  localparam int unsigned c_occ_w = c_idx_w + 1;
  localparam int unsigned c_max_w = NUM_LANES * WIDTH_IN;
  localparam int unsigned c_den_w = NUM_LANES * WIDTH_ACC;

  localparam logic c_op_alloc  = 1'b0;
  localparam logic c_op_load   = 1'b1;
  localparam logic c_op_update = 1'b0;
  localparam logic c_op_free   = 1'b1;

  // One extra bit so the range check also works when N_SLOTS fills the field.
  localparam logic [SLOT_ADDR_BITS:0] c_n_slots_ext = (SLOT_ADDR_BITS+1)'(N_SLOTS);
  localparam logic [c_idx_w-1:0]      c_last_idx    = c_idx_w'(N_SLOTS - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_e               r_state;
  state_e               w_state_next;
  logic [c_idx_w-1:0]   r_cnt;
  logic [c_idx_w-1:0]   w_cnt_next;

  logic [N_SLOTS-1:0]   r_valid;
  logic [N_SLOTS-1:0]   w_valid_next;
  logic [c_max_w-1:0]   r_max [N_SLOTS];
  logic [c_den_w-1:0]   r_den [N_SLOTS];
  logic [c_occ_w-1:0]   r_occupancy;
  logic [c_occ_w-1:0]   w_occ_next;

  logic                       r_rsp_valid;
  logic [SLOT_ADDR_BITS-1:0]  r_rsp_addr;
  logic                       r_rsp_hit;
  logic [c_max_w-1:0]         r_rsp_max;
  logic [c_den_w-1:0]         r_rsp_den;

  // --------------------------------------------------------------------------
  // Handshakes and address decode
  // --------------------------------------------------------------------------
  logic               w_idle;
  logic               w_req_fire;
  logic               w_upd_fire;
  logic [c_idx_w-1:0] w_req_idx;
  logic [c_idx_w-1:0] w_upd_idx;
  logic               w_req_in_range;
  logic               w_upd_in_range;

  assign w_idle       = (r_state == ST_IDLE);
  assign req_ready_o  = w_idle && (!r_rsp_valid || rsp_ready_i);
  assign upd_ready_o  = w_idle;
  assign w_req_fire   = req_valid_i && req_ready_o;
  assign w_upd_fire   = upd_valid_i && upd_ready_o;

  assign w_req_idx      = req_addr_i[c_idx_w-1:0];
  assign w_upd_idx      = upd_addr_i[c_idx_w-1:0];
  assign w_req_in_range = ({1'b0, req_addr_i} < c_n_slots_ext);
  assign w_upd_in_range = ({1'b0, upd_addr_i} < c_n_slots_ext);

  logic w_upd_write;
  logic w_upd_free;
  logic w_alloc_write;

  // UPDATE only lands on a slot that is already live.
  assign w_upd_write = w_upd_fire && w_upd_in_range && (upd_op_i == c_op_update)
                       && r_valid[w_upd_idx];
  assign w_upd_free  = w_upd_fire && w_upd_in_range && (upd_op_i == c_op_free);

  // --------------------------------------------------------------------------
  // ALLOC victim: lowest-index free slot, judged on the current valid bits so
  // a slot freed in this same cycle is not yet a candidate.
  // --------------------------------------------------------------------------
  logic               w_alloc_found;
  logic [c_idx_w-1:0] w_alloc_idx;

  always_comb begin
    w_alloc_found = 1'b0;
    w_alloc_idx   = '0;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        w_alloc_found = 1'b1;
        w_alloc_idx   = c_idx_w'(i);
      end
    end
  end

  assign w_alloc_write = w_req_fire && (req_op_i == c_op_alloc) && w_alloc_found;

  // --------------------------------------------------------------------------
  // Response data for the request being accepted this cycle
  // --------------------------------------------------------------------------
  logic                       w_rsp_hit;
  logic [SLOT_ADDR_BITS-1:0]  w_rsp_addr;
  logic [c_max_w-1:0]         w_rsp_max;
  logic [c_den_w-1:0]         w_rsp_den;
  logic                       w_fwd_same_slot;

  // An update to the slot being loaded wins (write-first).
  assign w_fwd_same_slot = w_upd_fire && w_upd_in_range && w_req_in_range
                           && (w_upd_idx == w_req_idx);

  always_comb begin
    w_rsp_hit  = 1'b0;
    w_rsp_addr = '0;
    w_rsp_max  = '0;
    w_rsp_den  = '0;
    if (req_op_i == c_op_alloc) begin
      if (w_alloc_found) begin
        w_rsp_hit  = 1'b1;
        w_rsp_addr = SLOT_ADDR_BITS'(w_alloc_idx);
        w_rsp_max  = {NUM_LANES{MAX_RESET}};
        w_rsp_den  = '0;
      end
    end else begin
      w_rsp_addr = req_addr_i;
      if (w_req_in_range && r_valid[w_req_idx]) begin
        w_rsp_hit = 1'b1;
        w_rsp_max = r_max[w_req_idx];
        w_rsp_den = r_den[w_req_idx];
        if (w_fwd_same_slot) begin
          if (upd_op_i == c_op_free) begin
            w_rsp_hit = 1'b0;
            w_rsp_max = '0;
            w_rsp_den = '0;
          end else begin
            w_rsp_max = upd_maximum_i;
            w_rsp_den = upd_denominator_i;
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next valid vector and occupancy. Flush and channel ops are exclusive
  // because both ready signals are low in FLUSH.
  // --------------------------------------------------------------------------
  always_comb begin
    w_valid_next = r_valid;
    if (r_state == ST_FLUSH) begin
      w_valid_next[r_cnt] = 1'b0;
    end
    if (w_upd_free) begin
      w_valid_next[w_upd_idx] = 1'b0;
    end
    if (w_alloc_write) begin
      w_valid_next[w_alloc_idx] = 1'b1;
    end
  end

  always_comb begin
    w_occ_next = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      w_occ_next = w_occ_next + c_occ_w'(w_valid_next[i]);
    end
  end

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (flush_i) begin
          w_state_next = ST_FLUSH;
          w_cnt_next   = '0;
        end
      end
      ST_FLUSH: begin
        w_cnt_next = r_cnt + c_idx_w'(1);
        if (r_cnt == c_last_idx) begin
          w_state_next = ST_IDLE;
          w_cnt_next   = '0;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // --------------------------------------------------------------------------
  // Slot storage
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid     <= '0;
      r_occupancy <= '0;
      for (int i = 0; i < N_SLOTS; i++) begin
        r_max[i] <= '0;
        r_den[i] <= '0;
      end
    end else begin
      r_valid     <= w_valid_next;
      r_occupancy <= w_occ_next;
      if (w_upd_write) begin
        r_max[w_upd_idx] <= upd_maximum_i;
        r_den[w_upd_idx] <= upd_denominator_i;
      end
      if (w_alloc_write) begin
        r_max[w_alloc_idx] <= {NUM_LANES{MAX_RESET}};
        r_den[w_alloc_idx] <= '0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Response register: data only moves on an accept, so it stays stable
  // while the consumer stalls.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rsp_valid <= 1'b0;
      r_rsp_addr  <= '0;
      r_rsp_hit   <= 1'b0;
      r_rsp_max   <= '0;
      r_rsp_den   <= '0;
    end else if (w_req_fire) begin
      r_rsp_valid <= 1'b1;
      r_rsp_addr  <= w_rsp_addr;
      r_rsp_hit   <= w_rsp_hit;
      r_rsp_max   <= w_rsp_max;
      r_rsp_den   <= w_rsp_den;
    end else if (r_rsp_valid && rsp_ready_i) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign rsp_valid_o       = r_rsp_valid;
  assign rsp_addr_o        = r_rsp_addr;
  assign rsp_hit_o         = r_rsp_hit;
  assign rsp_maximum_o     = r_rsp_max;
  assign rsp_denominator_o = r_rsp_den;
  assign occupancy_o       = r_occupancy;
  assign busy_o            = (r_state == ST_FLUSH);

`ifdef SOFTEX_SLOT_STATS_EN
  // --------------------------------------------------------------------------
  // Hit / miss statistics, saturating. A miss is any request answered with
  // hit=0 (LOAD miss or ALLOC on a full file).
  // --------------------------------------------------------------------------
  logic [31:0] r_stat_hits;
  logic [31:0] r_stat_misses;

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_stat_hits   <= '0;
      r_stat_misses <= '0;
    end else if (w_req_fire) begin
      if (w_rsp_hit && (req_op_i == c_op_load)) begin
        if (r_stat_hits != 32'hFFFF_FFFF) begin
          r_stat_hits <= r_stat_hits + 32'd1;
        end
      end else if (!w_rsp_hit) begin
        if (r_stat_misses != 32'hFFFF_FFFF) begin
          r_stat_misses <= r_stat_misses + 32'd1;
        end
      end
    end
  end

  assign stat_hits_o   = r_stat_hits;
  assign stat_misses_o = r_stat_misses;
`endif

endmodule
`default_nettype wire

// File: tb/tb_softex_slot_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_softex_slot_regfile
// Description : Directed self-checking bench for softex_slot_regfile.
//               Inputs change 1 ns after the rising edge; outputs are
//               checked at that same point, after the edge has settled.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_softex_slot_regfile;

  localparam int unsigned AW = 8;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          req_valid;
  logic          req_ready;
  logic          req_op;
  logic [AW-1:0] req_addr;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [AW-1:0] rsp_addr;
  logic          rsp_hit;
  logic [15:0]   rsp_max;
  logic [31:0]   rsp_den;
  logic          upd_valid;
  logic          upd_ready;
  logic          upd_op;
  logic [AW-1:0] upd_addr;
  logic [15:0]   upd_max;
  logic [31:0]   upd_den;
  logic [2:0]    occupancy;
  logic          busy;
`ifdef SOFTEX_SLOT_STATS_EN
  logic [31:0]   stat_hits;
  logic [31:0]   stat_misses;
`endif

  int n_pass  = 0;
  int n_total = 0;

  softex_slot_regfile dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .flush_i           (flush),
    .req_valid_i       (req_valid),
    .req_ready_o       (req_ready),
    .req_op_i          (req_op),
    .req_addr_i        (req_addr),
    .rsp_valid_o       (rsp_valid),
    .rsp_ready_i       (rsp_ready),
    .rsp_addr_o        (rsp_addr),
    .rsp_hit_o         (rsp_hit),
    .rsp_maximum_o     (rsp_max),
    .rsp_denominator_o (rsp_den),
    .upd_valid_i       (upd_valid),
    .upd_ready_o       (upd_ready),
    .upd_op_i          (upd_op),
    .upd_addr_i        (upd_addr),
    .upd_maximum_i     (upd_max),
    .upd_denominator_i (upd_den),
    .occupancy_o       (occupancy),
`ifdef SOFTEX_SLOT_STATS_EN
    .stat_hits_o       (stat_hits),
    .stat_misses_o     (stat_misses),
`endif
    .busy_o            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0;
    req_valid = 1'b0; req_op = 1'b0; req_addr = '0;
    upd_valid = 1'b0; upd_op = 1'b0; upd_addr = '0; upd_max = '0; upd_den = '0;
    rsp_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    n_total++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got=%0b exp=0", rsp_valid); else n_pass++;
    n_total++; if (rsp_hit !== 1'b0 || rsp_addr !== 8'd0 || rsp_max !== 16'd0 || rsp_den !== 32'd0)
      $display("FAIL reset_rsp_data got hit=%0b addr=%0d max=%h den=%h exp=0", rsp_hit, rsp_addr, rsp_max, rsp_den);
    else n_pass++;
    n_total++; if (occupancy !== 3'd0) $display("FAIL reset_occupancy got=%0d exp=0", occupancy); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%0b exp=0", busy); else n_pass++;
    n_total++; if (req_ready !== 1'b1 || upd_ready !== 1'b1)
      $display("FAIL reset_ready got req=%0b upd=%0b exp=1/1", req_ready, upd_ready);
    else n_pass++;
  endtask

  // Four back-to-back ALLOCs fill slots 0..3 in order.
  task automatic test_alloc_fill();
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_op = 1'b0; req_addr = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_total++;
      if (rsp_valid !== 1'b1 || rsp_hit !== 1'b1 || rsp_addr !== 8'(i) ||
          rsp_max !== 16'hFF80 || rsp_den !== 32'd0)
        $display("FAIL alloc_fill[%0d] got v=%0b hit=%0b addr=%0d max=%h den=%h exp v=1 hit=1 addr=%0d max=ff80 den=0",
                 i, rsp_valid, rsp_hit, rsp_addr, rsp_max, rsp_den, i);
      else n_pass++;
    end
    req_valid = 1'b0;
    n_total++; if (occupancy !== 3'd4) $display("FAIL alloc_fill_occupancy got=%0d exp=4", occupancy); else n_pass++;
    tick();
    n_total++; if (rsp_valid !== 1'b0) $display("FAIL alloc_fill_drain got=%0b exp=0", rsp_valid); else n_pass++;
  endtask

  task automatic test_alloc_full();
    req_valid = 1'b1; req_op = 1'b0;
    tick();
    req_valid = 1'b0;
    n_total++;
    if (rsp_valid !== 1'b1 || rsp_hit !== 1'b0 || rsp_addr !== 8'd0 || rsp_max !== 16'd0 || rsp_den !== 32'd0)
      $display("FAIL alloc_full got v=%0b hit=%0b addr=%0d max=%h den=%h exp v=1 hit=0 addr=0 max=0 den=0",
               rsp_valid, rsp_hit, rsp_addr, rsp_max, rsp_den);
    else n_pass++;
    n_total++; if (occupancy !== 3'd4) $display("FAIL alloc_full_occupancy got=%0d exp=4", occupancy); else n_pass++;
    tick();
  endtask

  task automatic test_update_load();
    upd_valid = 1'b1; upd_op = 1'b0; upd_addr = 8'd2; upd_max = 16'h3F80; upd_den = 32'h4000_0000;
    tick();
    upd_valid = 1'b0;
    req_valid = 1'b1; req_op = 1'b1; req_addr = 8'd2;
    tick();
    n_total++;
    if (rsp_hit !== 1'b1 || rsp_addr !== 8'd2 || rsp_max !== 16'h3F80 || rsp_den !== 32'h4000_0000)
      $display("FAIL load_2 got hit=%0b addr=%0d max=%h den=%h exp hit=1 addr=2 max=3f80 den=40000000",
               rsp_hit, rsp_addr, rsp_max, rsp_den);
    else n_pass++;
    req_addr = 8'd7;
    tick();
    req_valid = 1'b0;
    n_total++;
    if (rsp_valid !== 1'b1 || rsp_hit !== 1'b0 || rsp_max !== 16'd0 || rsp_den !== 32'd0)
      $display("FAIL load_7_out_of_range got v=%0b hit=%0b max=%h den=%h exp v=1 hit=0 max=0 den=0",
               rsp_valid, rsp_hit, rsp_max, rsp_den);
    else n_pass++;
    tick();
  endtask

  task automatic test_same_cycle();
    // UPDATE and LOAD of slot 1 together: load sees the new data.
    upd_valid = 1'b1; upd_op = 1'b0; upd_addr = 8'd1; upd_max = 16'h1234; upd_den = 32'h3F80_0000;
    req_valid = 1'b1; req_op = 1'b1; req_addr = 8'd1;
    tick();
    n_total++;
    if (rsp_hit !== 1'b1 || rsp_max !== 16'h1234 || rsp_den !== 32'h3F80_0000)
      $display("FAIL fwd_update_load got hit=%0b max=%h den=%h exp hit=1 max=1234 den=3f800000",
               rsp_hit, rsp_max, rsp_den);
    else n_pass++;
    // FREE 3 and ALLOC with the file full: ALLOC must not see slot 3.
    upd_op = 1'b1; upd_addr = 8'd3;
    req_op = 1'b0; req_addr = 8'd0;
    tick();
    upd_valid = 1'b0;
    n_total++; if (rsp_hit !== 1'b0) $display("FAIL free_alloc_same_cycle_hit got=%0b exp=0", rsp_hit); else n_pass++;
    n_total++; if (occupancy !== 3'd3) $display("FAIL free_occupancy got=%0d exp=3", occupancy); else n_pass++;
    tick();
    req_valid = 1'b0;
    n_total++;
    if (rsp_hit !== 1'b1 || rsp_addr !== 8'd3)
      $display("FAIL alloc_after_free got hit=%0b addr=%0d exp hit=1 addr=3", rsp_hit, rsp_addr);
    else n_pass++;
    n_total++; if (occupancy !== 3'd4) $display("FAIL realloc_occupancy got=%0d exp=4", occupancy); else n_pass++;
    tick();
  endtask

  task automatic test_back_to_back();
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_op = 1'b1; req_addr = 8'd2;
    tick();
    req_addr = 8'd1;  // second request waits behind the stalled response
    for (int k = 0; k < 5; k++) begin
      n_total++;
      if (rsp_valid !== 1'b1 || rsp_addr !== 8'd2 || rsp_max !== 16'h3F80 ||
          rsp_den !== 32'h4000_0000 || req_ready !== 1'b0)
        $display("FAIL stall[%0d] got v=%0b addr=%0d max=%h den=%h rdy=%0b exp v=1 addr=2 max=3f80 den=40000000 rdy=0",
                 k, rsp_valid, rsp_addr, rsp_max, rsp_den, req_ready);
      else n_pass++;
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    n_total++; if (req_ready !== 1'b1) $display("FAIL handshake_ready got=%0b exp=1", req_ready); else n_pass++;
    tick();
    req_valid = 1'b0;
    n_total++;
    if (rsp_valid !== 1'b1 || rsp_addr !== 8'd1 || rsp_max !== 16'h1234 || rsp_den !== 32'h3F80_0000)
      $display("FAIL back_to_back got v=%0b addr=%0d max=%h den=%h exp v=1 addr=1 max=1234 den=3f800000",
               rsp_valid, rsp_addr, rsp_max, rsp_den);
    else n_pass++;
    tick();
  endtask

  task automatic test_flush();
    int busy_cycles;
    bool_blk: begin end
    busy_cycles = 0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int k = 0; k < 10 && busy === 1'b1; k++) begin
      busy_cycles++;
      n_total++;
      if (req_ready !== 1'b0 || upd_ready !== 1'b0)
        $display("FAIL flush_ready[%0d] got req=%0b upd=%0b exp 0/0", k, req_ready, upd_ready);
      else n_pass++;
      tick();
    end
    n_total++; if (busy_cycles != 4) $display("FAIL flush_busy_cycles got=%0d exp=4", busy_cycles); else n_pass++;
    n_total++; if (occupancy !== 3'd0) $display("FAIL flush_occupancy got=%0d exp=0", occupancy); else n_pass++;
    req_valid = 1'b1; req_op = 1'b1; req_addr = 8'd0;
    tick();
    req_valid = 1'b0;
    n_total++;
    if (rsp_valid !== 1'b1 || rsp_hit !== 1'b0)
      $display("FAIL load_after_flush got v=%0b hit=%0b exp v=1 hit=0", rsp_valid, rsp_hit);
    else n_pass++;
    tick();
  endtask

  initial begin
    test_reset();
    test_alloc_fill();
    test_alloc_full();
    test_update_load();
    test_same_cycle();
    test_back_to_back();
    test_flush();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/softex_slot_regfile.md
Name: softex_slot_regfile

Overview:
- Responder side of the softex slot protocol: owns the per-row softmax state slots (running maximum and denominator, one per lane) and serves slot requests and slot updates from the softex controller.
- Request ops: ALLOC, LOAD. Update ops: UPDATE, FREE.
- Sits between the controller and the datapath. It lets partial softmax reductions be parked and resumed across commands.

Parameters:
- N_SLOTS, 4, number of slots held; power of two, 2..64.
- SLOT_ADDR_BITS, 8, width of the slot address fields.
- WIDTH_IN, 16, maximum field width (FP16ALT).
- WIDTH_ACC, 32, denominator field width (FP32).
- NUM_LANES, 1, lanes per slot.
- MAX_RESET, 16'hFF80, value written to maximum on ALLOC (FP16ALT -inf).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- flush_i  in  1  pulse; invalidate all slots
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request ready
- req_op_i  in  1  0=ALLOC, 1=LOAD
- req_addr_i  in  SLOT_ADDR_BITS  slot address (LOAD only)
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response ready
- rsp_addr_o  out  SLOT_ADDR_BITS  allocated or loaded address
- rsp_hit_o  out  1  LOAD found a valid slot / ALLOC succeeded
- rsp_maximum_o  out  NUM_LANES*WIDTH_IN  slot maximum
- rsp_denominator_o  out  NUM_LANES*WIDTH_ACC  slot denominator
- upd_valid_i  in  1  update valid
- upd_ready_o  out  1  update ready
- upd_op_i  in  1  0=UPDATE, 1=FREE
- upd_addr_i  in  SLOT_ADDR_BITS  target slot
- upd_maximum_i  in  NUM_LANES*WIDTH_IN  new maximum
- upd_denominator_i  in  NUM_LANES*WIDTH_ACC  new denominator
- occupancy_o  out  $clog2(N_SLOTS)+1  number of valid slots
- busy_o  out  1  flush in progress

Behaviour:
- Reset values:
  - all slot valid bits 0; slot data 0.
  - rsp_valid_o=0; rsp_* data outputs 0.
  - occupancy_o=0, busy_o=0; FSM in IDLE.
  - upd_ready_o and req_ready_o follow their combinational rules from IDLE.
- FSM states: IDLE, FLUSH.
  - IDLE -> FLUSH when flush_i=1.
  - FLUSH clears valid of slot index cnt, one per cycle, cnt = 0..N_SLOTS-1.
  - FLUSH -> IDLE after clearing slot N_SLOTS-1, i.e. N_SLOTS cycles in FLUSH.
  - busy_o=1 while in FLUSH.
  - flush_i while already in FLUSH is ignored.
- Ready rules:
  - req_ready_o = (state==IDLE) && (!rsp_valid_o || rsp_ready_i).
  - upd_ready_o = (state==IDLE).
- Response path is a single output register.
  - A request accepted in cycle N gives rsp_valid_o=1 in cycle N+1.
  - Response data holds stable until rsp_valid_o && rsp_ready_i.
  - A new accept in the same cycle as a handshake gives back-to-back responses.
- Address decode:
  - slot index = req_addr_i[$clog2(N_SLOTS)-1:0].
  - Any address >= N_SLOTS is out of range.
- ALLOC:
  - Picks the lowest-index slot with valid=0.
  - Sets valid=1, maximum=MAX_RESET in every lane, denominator=0.
  - Responds rsp_hit_o=1, rsp_addr_o=index, data = initialised values.
  - If all slots are valid: state unchanged; rsp_hit_o=0, rsp_addr_o=0, data=0.
- LOAD:
  - In range and valid: rsp_hit_o=1, data = slot contents, rsp_addr_o = req_addr_i.
  - Otherwise: rsp_hit_o=0, data=0.
- UPDATE:
  - Valid, in-range slot: overwrite maximum and denominator.
  - Invalid or out-of-range slot: ignored.
- FREE:
  - Clears valid of an in-range slot.
  - Freeing an already invalid slot is a no-op.
- Simultaneous request and update in the same cycle:
  - LOAD of the same slot as an UPDATE returns the new update data (write-first forwarding).
  - LOAD of the same slot as a FREE returns rsp_hit_o=0.
  - ALLOC does not consider a slot freed in that same cycle.
  - ALLOC and UPDATE never target the same slot, because UPDATE needs valid=1 and ALLOC picks valid=0.
- occupancy_o is registered and updates the cycle after any valid change. Values 0..N_SLOTS.
- flush_i in the same cycle as an accepted request or update:
  - The request or update completes first.
  - FLUSH starts next cycle and clears the result as well.
  - A pending response is not dropped by flush.
- Synchronous reset mid-FLUSH or with a pending response returns to reset values at the next edge.

Optional Feature:
- Macro: SOFTEX_SLOT_STATS_EN.
- When defined, adds outputs:
  - stat_hits_o [31:0]: counts LOAD hits.
  - stat_misses_o [31:0]: counts LOAD misses plus ALLOC failures.
  - Both count at request acceptance, saturate at 32'hFFFFFFFF, and clear on rst_i or flush_i.
- When undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then 4 ALLOCs with rsp_ready_i=1 -> rsp_addr_o 0,1,2,3, each one cycle after accept; rsp_hit_o=1; maximum 16'hFF80; denominator 0; occupancy_o=4.
- Fifth ALLOC when full -> rsp_hit_o=0, rsp_addr_o=0; occupancy_o stays 4.
- UPDATE slot 2 (max 16'h3F80, den 32'h40000000), then LOAD 2 -> hit=1 with those values; LOAD 7 -> hit=0, data 0.
- Same cycle: UPDATE slot 1 (den 32'h3F800000) and LOAD 1 -> response den 32'h3F800000. Same cycle: FREE 3 and ALLOC with all slots full -> hit=0; the next ALLOC returns addr 3.
- Hold rsp_ready_i=0 for 5 cycles after a LOAD -> rsp_valid_o stays 1 with stable data; req_ready_o=0; the second request is accepted on the handshake cycle.
- flush_i with 4 valid slots -> busy_o=1 for exactly 4 cycles; req_ready_o=0 throughout; occupancy_o=0 afterward; LOAD 0 -> hit=0.
